ahb_spi_fifo: RTL

AHB_SPI_FIFO -- requirements
Module: ahb_spi_fifo

---
 rtl/ahb_spi_fifo_pkg.sv | 35 +++
 rtl/spi_byte_fifo.sv | 51 +++++
 rtl/ahb_spi_fifo.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_spi_fifo_pkg.sv
// Shared register map, CTRL/STATUS bit positions and engine state encoding for ahb_spi_fifo.
package ahb_spi_fifo_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_SS_SEL = 8'h08;
    localparam logic [7:0] ADDR_TXDATA = 8'h0C;
    localparam logic [7:0] ADDR_RXDATA = 8'h10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CPOL    = 1;
    localparam int CTRL_CPHA    = 2;
    localparam int CTRL_SS_AH   = 3;
    localparam int CTRL_IRQ_EN  = 4;
    localparam int CTRL_DIV_LSB = 8;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_TX_EMPTY   = 2;
    localparam int STAT_RX_FULL    = 3;
    localparam int STAT_RX_EMPTY   = 4;
    localparam int STAT_TX_OVF     = 5;
    localparam int STAT_RX_UNF     = 6;
    localparam int STAT_TX_LVL_LSB = 8;
    localparam int STAT_RX_LVL_LSB = 16;

    // Index of the final half-period of an 8-bit frame.
    localparam logic [3:0] LAST_HALF = 4'd15;

    typedef enum logic {
        ENG_IDLE  = 1'b0,
        ENG_SHIFT = 1'b1
    } eng_state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte-wide synchronous FIFO with exact occupancy; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module spi_byte_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ahb_spi_fifo.sv
// AHB-Lite SPI master with TX/RX byte FIFOs and a single-frame shift engine.
// Define AHB_SPI_FIFO_IRQ_EN to add CTRL[4] IRQ_EN and the registered SPI_IRQ_o output.
module ahb_spi_fifo
    import ahb_spi_fifo_pkg::*;
#(
    parameter int NUM_SS     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic [31:0]       HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    input  logic              SPI_MISO_i,
    output logic              SPI_MOSI_o,
    output logic              SPI_CLK_o,
    output logic [NUM_SS-1:0] SPI_SS_o,
`ifdef AHB_SPI_FIFO_IRQ_EN
    output logic              SPI_IRQ_o,
`endif
    output eng_state_e        engine_state
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        addr_q;
    logic              wr_q, rd_q;
    logic              en, cpol, cpha, ss_ah, irq_en;
    logic [DIV_W-1:0]  clkdiv;
    logic [NUM_SS-1:0] ss_sel;
    logic              tx_ovf, rx_unf;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [LW-1:0]     tx_level, rx_level;
    logic [7:0]        tx_data, rx_data, rx_byte;
    logic              tx_pop, rx_push, half_tick, busy;
    eng_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_cnt;
    logic [3:0]        half_cnt;
    logic [7:0]        tx_sr, rx_sr;
    logic              sclk, mosi;
    logic [31:0]       ctrl_word, status_word;
    logic              unused_bits;

    assign unused_bits = ^{HADDR, HWDATA, HSIZE, HTRANS};

    logic wr_ctrl, wr_status, wr_ss, wr_tx, rd_rx;
    assign wr_ctrl   = wr_q && (addr_q == ADDR_CTRL);
    assign wr_status = wr_q && (addr_q == ADDR_STATUS);
    assign wr_ss     = wr_q && (addr_q == ADDR_SS_SEL);
    assign wr_tx     = wr_q && (addr_q == ADDR_TXDATA);
    assign rd_rx     = rd_q && (addr_q == ADDR_RXDATA);

    assign busy         = (state_q == ENG_SHIFT);
    assign HREADYOUT    = 1'b1;
    assign SPI_SS_o     = ss_ah ? ss_sel : ~ss_sel;
    assign SPI_CLK_o    = sclk;
    assign SPI_MOSI_o   = mosi;
    assign engine_state = state_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            addr_q <= HADDR[7:0];
            wr_q   <= HSEL && HREADY && HTRANS[1] && HWRITE;
            rd_q   <= HSEL && HREADY && HTRANS[1] && !HWRITE;
        end
    end

    // Mode and divider are frozen while a frame is on the wire.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            en     <= 1'b0;
            cpol   <= 1'b0;
            cpha   <= 1'b0;
            ss_ah  <= 1'b0;
            clkdiv <= '0;
            ss_sel <= '0;
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en    <= HWDATA[CTRL_EN];
                ss_ah <= HWDATA[CTRL_SS_AH];
                if (!busy) begin
                    cpol   <= HWDATA[CTRL_CPOL];
                    cpha   <= HWDATA[CTRL_CPHA];
                    clkdiv <= HWDATA[CTRL_DIV_LSB +: DIV_W];
                end
            end
            if (wr_ss) ss_sel <= HWDATA[NUM_SS-1:0];
            if (wr_tx && tx_full && !tx_pop)         tx_ovf <= 1'b1;
            else if (wr_status && HWDATA[STAT_TX_OVF]) tx_ovf <= 1'b0;
            if (rd_rx && rx_empty)                   rx_unf <= 1'b1;
            else if (wr_status && HWDATA[STAT_RX_UNF]) rx_unf <= 1'b0;
        end
    end

`ifdef AHB_SPI_FIFO_IRQ_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_en    <= 1'b0;
            SPI_IRQ_o <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= HWDATA[CTRL_IRQ_EN];
            SPI_IRQ_o <= irq_en && (!rx_empty || tx_ovf || rx_unf);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        ctrl_word                             = '0;
        ctrl_word[CTRL_EN]                    = en;
        ctrl_word[CTRL_CPOL]                  = cpol;
        ctrl_word[CTRL_CPHA]                  = cpha;
        ctrl_word[CTRL_SS_AH]                 = ss_ah;
        ctrl_word[CTRL_IRQ_EN]                = irq_en;
        ctrl_word[CTRL_DIV_LSB +: DIV_W]      = clkdiv;
        status_word                           = '0;
        status_word[STAT_BUSY]                = busy;
        status_word[STAT_TX_FULL]             = tx_full;
        status_word[STAT_TX_EMPTY]            = tx_empty;
        status_word[STAT_RX_FULL]             = rx_full;
        status_word[STAT_RX_EMPTY]            = rx_empty;
        status_word[STAT_TX_OVF]              = tx_ovf;
        status_word[STAT_RX_UNF]              = rx_unf;
        status_word[STAT_TX_LVL_LSB +: 8]     = 8'(tx_level);
        status_word[STAT_RX_LVL_LSB +: 8]     = 8'(rx_level);
        HRDATA = '0;
        if (rd_q) begin
            case (addr_q)
                ADDR_CTRL:   HRDATA = ctrl_word;
                ADDR_STATUS: HRDATA = status_word;
                ADDR_SS_SEL: HRDATA = 32'(ss_sel);
                ADDR_RXDATA: HRDATA = rx_empty ? 32'h0 : {24'h0, rx_data};
                default:     HRDATA = '0;
            endcase
        end
    end

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(HCLK), .rst(HRESET), .push(wr_tx), .push_data(HWDATA[7:0]),
        .pop(tx_pop), .pop_data(tx_data), .full(tx_full), .empty(tx_empty),
        .level(tx_level)
    );

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(HCLK), .rst(HRESET), .push(rx_push), .push_data(rx_byte),
        .pop(rd_rx), .pop_data(rx_data), .full(rx_full), .empty(rx_empty),
        .level(rx_level)
    );

    // With CPHA=1 the final sample lands on the last edge, so merge it directly.
    assign rx_byte = cpha ? {rx_sr[6:0], SPI_MISO_i} : rx_sr;

    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= ENG_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        half_tick = 1'b0;
        case (state_q)
            ENG_IDLE: begin
                if (en && !tx_empty && !rx_full) begin
                    state_d = ENG_SHIFT;
                    tx_pop  = 1'b1;
                end
            end
            ENG_SHIFT: begin
                half_tick = (div_cnt == clkdiv);
                if (half_tick && half_cnt == LAST_HALF) begin
                    state_d = ENG_IDLE;
                    rx_push = 1'b1;
                end
            end
            default: state_d = ENG_IDLE;
        endcase
    end

    // Even half indices end on a leading edge; CPHA picks sample vs. shift.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else if (state_q == ENG_IDLE) begin
            sclk     <= cpol;
            div_cnt  <= '0;
            half_cnt <= '0;
            if (tx_pop) begin
                if (!cpha) begin
                    mosi  <= tx_data[7];
                    tx_sr <= {tx_data[6:0], 1'b0};
                end else begin
                    tx_sr <= tx_data;
                end
            end
        end else if (half_tick) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            half_cnt <= half_cnt + 1'b1;
            if (half_cnt[0] == cpha) begin
                rx_sr <= {rx_sr[6:0], SPI_MISO_i};
            end else begin
                mosi  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule
